uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver (start + 8 data [+ even parity when UART_RX_PARITY_EN] + stop) with RX_DATA and W1C STATUS registers.
// Data/flags update one cycle after the stop sample; reads return next cycle; no backpressure, a load over unread data sets overrun.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        load_q, ferr_set_q, perr_set_q;

  logic [7:0]  data_q, data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] status;
  logic        rd_rx, w1c;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[31:4], wr_data[0]};

  // Receive FSM; load/flag pulses are registered so the register bank sees them one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      load_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      perr_set_q <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      load_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      perr_set_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == LAST) begin
            cnt_q      <= '0;
            perr_set_q <= (rx_s2_q != ^shift_q);
            state_q    <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            load_q     <= rx_s2_q;
            ferr_set_q <= !rx_s2_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A load beats a same-cycle read, and a flag set beats a same-cycle W1C.
  always_comb begin
    rd_rx        = sel & ~we & ~addr;
    w1c          = sel & we & addr;
    status       = {28'b0, overrun_q, frame_err_q, parity_err_q, rx_valid_q};
    data_d       = load_q ? shift_q : data_q;
    rx_valid_d   = rx_valid_q;
    if (rd_rx)  rx_valid_d = 1'b0;
    if (load_q) rx_valid_d = 1'b1;
    overrun_d    = (overrun_q & ~(w1c & wr_data[3])) | (load_q & rx_valid_q & ~rd_rx);
    frame_err_d  = (frame_err_q & ~(w1c & wr_data[2])) | ferr_set_q;
    parity_err_d = (parity_err_q & ~(w1c & wr_data[1])) | perr_set_q;
    rd_data_d    = rd_data_q;
    if (sel && !we) rd_data_d = addr ? status : {24'b0, data_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      data_q       <= data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = rx_valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLKS_PER_BIT = 8; expectations follow UART_RX_PARITY_EN as seen by the build.
module tb_uart_rx_ctrl;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(p);
    drive_bit(stp);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rd_data;
  endtask

  task automatic bus_wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wr_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_rd(1'b1, rd);
    check("reset_status", rd, 32'h0);

    // Clean frame 0x0C, even parity 0
    send_frame(8'h0C, 1'b0, 1'b1);
    check("f0c_irq", {31'b0, irq}, 32'h1);
    bus_rd(1'b1, rd);
    check("f0c_status", rd, 32'h1);
    bus_rd(1'b0, rd);
    check("f0c_data", rd, 32'h0000000C);
    bus_rd(1'b1, rd);
    check("f0c_status_after_read", rd, 32'h0);
    check("f0c_irq_after_read", {31'b0, irq}, 32'h0);

    // 0x0E has odd weight, so parity 0 is an error
    send_frame(8'h0E, 1'b0, 1'b1);
    bus_rd(1'b1, rd);
    check("f0e_perr_status", rd, PAR_EN ? 32'h3 : 32'h1);
    bus_wr(1'b1, 32'h2);
    bus_rd(1'b1, rd);
    check("f0e_w1c_status", rd, 32'h1);
    bus_rd(1'b0, rd);
    check("f0e_data", rd, 32'h0000000E);

    // Stop bit 0: frame error, data untouched
    send_frame(8'h03, 1'b0, 1'b0);
    bus_rd(1'b1, rd);
    check("ferr_status", rd, 32'h4);
    check("ferr_irq", {31'b0, irq}, 32'h0);
    bus_rd(1'b0, rd);
    check("ferr_data_kept", rd, 32'h0000000E);
    bus_wr(1'b1, 32'h4);
    bus_rd(1'b1, rd);
    check("ferr_cleared", rd, 32'h0);

    // Two frames back to back without a read: overrun
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h0E, 1'b1, 1'b1);
    bus_rd(1'b1, rd);
    check("ovr_status", rd, 32'h9);
    bus_wr(1'b1, 32'h9);
    bus_rd(1'b1, rd);
    check("ovr_w1c_keeps_valid", rd, 32'h1);
    bus_wr(1'b0, 32'hFF);
    bus_rd(1'b0, rd);
    check("ovr_data", rd, 32'h0000000E);
    bus_rd(1'b1, rd);
    check("ovr_status_final", rd, 32'h0);

    // Glitch: 3 cycles low is rejected at the start mid-sample
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    bus_rd(1'b1, rd);
    check("glitch_status", rd, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    send_frame(8'h0C, 1'b0, 1'b1);
    bus_rd(1'b0, rd);
    check("glitch_recover_data", rd, 32'h0000000C);

    // Reset during data bit 4 of a 0x0F frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rd_data", rd_data, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    bus_rd(1'b1, rd);
    check("midrst_status", rd, 32'h0);
    send_frame(8'h0E, 1'b1, 1'b1);
    bus_rd(1'b1, rd);
    check("postrst_status", rd, 32'h1);
    bus_rd(1'b0, rd);
    check("postrst_data", rd, 32'h0000000E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
